// File: rtl/peridot_txd_arbiter.sv
// peridot_txd_arbiter: four-way round-robin packet arbiter that feeds a UART sender phy.
// One requester at a time holds the grant. It keeps the grant until a byte marked eop is
// accepted, or until its valid has stayed low for TIMEOUT_CYCLES cycles. Data and ready
// pass through combinationally while a grant is held.
// Optional feature: define PERIDOT_TXARB_HEADER_EN to send a header byte 8'hF0|grant
// before the payload of each packet.
module peridot_txd_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic        clock_sig,
  input  logic        reset_sig,
  input  logic [3:0]  sink_valid,
  input  logic [31:0] sink_data,
  input  logic [3:0]  sink_eop,
  output logic [3:0]  sink_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic [1:0]  grant_ch
);

  localparam logic [1:0] StIdle    = 2'd0;
`ifdef PERIDOT_TXARB_HEADER_EN
  localparam logic [1:0] StHeader  = 2'd1;
`endif
  localparam logic [1:0] StForward = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;

  logic [1:0]  rr_pick;
  logic [1:0]  rr_idx;
  logic        rr_found;
  logic        sel_valid;
  logic        sel_eop;
  logic [7:0]  sel_data;
  logic        xfer;
  logic        timeout_hit;

  // Lanes of the granted requester.
  assign sel_valid = sink_valid[grant_q];
  assign sel_eop   = sink_eop[grant_q];
  assign sel_data  = sink_data[{grant_q, 3'b000} +: 8];

  assign xfer        = out_valid & out_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 16'd0) && (idle_cnt_q == TIMEOUT_CYCLES);

  assign busy     = (state_q != StIdle);
  assign grant_ch = grant_q;

  // Round-robin search. It starts just after the last grant; i = 4 wraps back to that grant.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = 2'd0;
    rr_idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      rr_idx = last_grant_q + i[1:0];
      if (!rr_found && sink_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  // Output mux: everything is idle except the granted lane.
  always_comb begin
    out_valid  = 1'b0;
    out_data   = 8'h00;
    sink_ready = 4'b0000;
    case (state_q)
      StForward: begin
        out_valid           = sel_valid;
        out_data            = sel_data;
        sink_ready[grant_q] = out_ready;
      end
`ifdef PERIDOT_TXARB_HEADER_EN
      StHeader: begin
        out_valid = 1'b1;
        out_data  = 8'hF0 | {6'd0, grant_q};
      end
`endif
      default: ;
    endcase
  end

  // Next-state logic: arbitration, end-of-packet and idle timeout.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    idle_cnt_d   = idle_cnt_q;
    case (state_q)
      StIdle: begin
        if (rr_found) begin
          grant_d    = rr_pick;
          idle_cnt_d = 16'd0;
`ifdef PERIDOT_TXARB_HEADER_EN
          state_d    = StHeader;
`else
          state_d    = StForward;
`endif
        end
      end
`ifdef PERIDOT_TXARB_HEADER_EN
      StHeader: begin
        // The timeout does not run while the header byte waits for the phy.
        if (out_ready) begin
          state_d    = StForward;
          idle_cnt_d = 16'd0;
        end
      end
`endif
      StForward: begin
        if (xfer) begin
          idle_cnt_d = 16'd0;
        end else if (!sel_valid && (idle_cnt_q != 16'hFFFF)) begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
        // If eop and timeout happen in the same cycle, both give the same result.
        if ((xfer && sel_eop) || timeout_hit) begin
          state_d      = StIdle;
          last_grant_d = grant_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers. Reset is asynchronous; last_grant = 3 lets requester 0 win first.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_q      <= StIdle;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      idle_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

endmodule
